// File: rtl/io_perif_pkg.sv
// io_perif_pkg: address map and data width shared by the io_perif block and its bus interface.
package io_perif_pkg;
    localparam int DATA_W = 16;
    localparam logic [DATA_W-1:0] ADDR_PORT   = 16'h0000;
    localparam logic [DATA_W-1:0] ADDR_FLAGS  = 16'h0001;
    localparam logic [DATA_W-1:0] ADDR_TIMER  = 16'h0002;
    localparam logic [DATA_W-1:0] ADDR_STATUS = 16'h0003;
endpackage

// File: rtl/io_perif_if.sv
// io_perif_if: CPU read bus between the datapath (master) and io_perif (slave).
interface io_perif_if;
    logic [io_perif_pkg::DATA_W-1:0] Direcciones;
    logic                            rd_en;
    logic [io_perif_pkg::DATA_W-1:0] Datos;
    modport master(output Direcciones, output rd_en, input Datos);
    modport slave(input Direcciones, input rd_en, output Datos);
endinterface

// File: rtl/io_perif_sincro.sv
// sincro: two-flop synchronizer for asynchronous input lines, async active-high reset.
module sincro #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1_q, s1_d, s2_q, s2_d;
    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/io_perif.sv
// io_perif: switch port with sticky rising-edge flags and an optional prescaled timer.
// Timer, prescaler and overflow status exist only when IO_PERIF_TIMER_EN is defined.
module io_perif
    import io_perif_pkg::*;
#(
    parameter logic [15:0] PRESCALE  = 16'd1000,
    parameter logic [15:0] TIMER_MAX = 16'hFFFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] sw_in,
    io_perif_if.slave  bus
);
    logic [7:0] sync, port_q, port_d, flags_q, flags_d;
    logic [DATA_W-1:0] timer_rd, status_rd;
    logic clr_flags;
    sincro #(.W(8)) u_sincro (.clk(clk), .reset(reset), .d(sw_in), .q(sync));
    // port_q is the previous synchronized sample, so it doubles as the edge-detect history
    always_comb begin
        clr_flags = bus.rd_en && (bus.Direcciones == ADDR_FLAGS);
        port_d    = sync;
        flags_d   = (flags_q & ~{8{clr_flags}}) | (sync & ~port_q);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q  <= '0;
            flags_q <= '0;
        end else begin
            port_q  <= port_d;
            flags_q <= flags_d;
        end
    end
`ifdef IO_PERIF_TIMER_EN
    logic [15:0] pre_q, pre_d, timer_q, timer_d;
    logic ovf_q, ovf_d, tick, wrap, clr_status;
    always_comb begin
        tick       = (pre_q == PRESCALE - 16'd1);
        pre_d      = tick ? '0 : pre_q + 16'd1;
        wrap       = tick && (timer_q == TIMER_MAX);
        timer_d    = wrap ? '0 : timer_q + {15'd0, tick};
        clr_status = bus.rd_en && (bus.Direcciones == ADDR_STATUS);
        ovf_d      = wrap | (ovf_q & ~clr_status);
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q   <= '0;
            timer_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pre_q   <= pre_d;
            timer_q <= timer_d;
            ovf_q   <= ovf_d;
        end
    end
    assign timer_rd  = timer_q;
    assign status_rd = {{(DATA_W-1){1'b0}}, ovf_q};
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = {PRESCALE, TIMER_MAX};
    assign timer_rd   = '0;
    assign status_rd  = '0;
`endif
    assign bus.Datos = (bus.Direcciones == ADDR_PORT)   ? {{(DATA_W-8){1'b0}}, port_q}  :
                       (bus.Direcciones == ADDR_FLAGS)  ? {{(DATA_W-8){1'b0}}, flags_q} :
                       (bus.Direcciones == ADDR_TIMER)  ? timer_rd :
                       (bus.Direcciones == ADDR_STATUS) ? status_rd : '0;
endmodule

// File: doc/io_perif.md
IO_PERIF -- requirements
Module: io_perif

Interface
REQ-001 Parameter PRESCALE, default 16'd1000, clk cycles per timer tick (legal 1..65535).
REQ-002 Parameter TIMER_MAX, default 16'hFFFF, last timer count value before wrap.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 Direcciones  input  16  read address driven by the CPU datapath.
REQ-006 rd_en  input  1  read strobe from the control unit; high during a load from Datos.
REQ-007 sw_in  input  8  external switch/button lines, asynchronous to clk.
REQ-008 Datos  output  16  read data returned to the datapath, combinational from Direcciones and registered state.

Function
REQ-009 Address map: 0x0000 port data, 0x0001 edge flags, 0x0002 timer count, 0x0003 timer status; any other address SHALL read 16'h0000.
REQ-010 sw_in SHALL pass through a 2-flop synchronizer; the port data register holds the synchronized value, zero-extended to 16 bits.
REQ-011 Edge flags[7:0] SHALL set bit i one cycle after synchronized sw_in[i] rises (0->1); flags are sticky.
REQ-012 Read-clear: rising edge with rd_en=1 and Direcciones=0x0001 SHALL clear edge flags captured before that edge.
REQ-013 Edge detected in the same cycle as a clearing read: set SHALL win for that bit.
REQ-014 Prescaler SHALL count 0..PRESCALE-1 and emit a one-cycle tick when it wraps to 0.
REQ-015 Timer count SHALL increment on each tick and wrap from TIMER_MAX to 0.
REQ-016 Wrap SHALL set status bit0 (overflow, sticky); status bits 15:1 read 0.
REQ-017 Clearing read at 0x0003 SHALL clear overflow; simultaneous wrap and clear SHALL leave overflow set.
REQ-018 Datos SHALL be valid in the same cycle as Direcciones, with zero added latency; the datapath writes it into the register file at the next edge.
REQ-019 Reads at 0x0000 and 0x0002 SHALL have no side effects; rd_en=0 SHALL never clear flags.

Reset
REQ-020 Asserting reset SHALL clear synchronizer flops, port data, edge flags, prescaler, timer count and overflow to 0.
REQ-021 Datos after reset SHALL be 16'h0000 for every address.
REQ-022 Reset asserted mid-count SHALL abort the count; counting restarts from 0 on the first edge after deassertion.

Configuration
REQ-023 Macro IO_PERIF_TIMER_EN defined: prescaler, timer and overflow logic SHALL be present as in REQ-014..017.
REQ-024 Macro IO_PERIF_TIMER_EN undefined: no timer logic SHALL be synthesized, and addresses 0x0002/0x0003 SHALL read 16'h0000.

Structure
REQ-025 Shared package SHALL hold the address constants ADDR_PORT, ADDR_FLAGS, ADDR_TIMER, ADDR_STATUS and the 16-bit data width constant.
REQ-026 Sub-module sincro SHALL implement one 2-flop synchronizer with asynchronous reset; it is instantiated once with 8-bit width.
REQ-027 Read mux and read-clear decode SHALL stay in io_perif.

Verification
REQ-028 Hold reset, drive sw_in=8'hFF, sweep Direcciones 0..3 -> Datos=0 at each address.
REQ-029 sw_in 8'h00->8'h05, wait 3 cycles, read 0x0000 -> 16'h0005; read 0x0001 with rd_en=1 -> 16'h0005, then next read -> 16'h0000.
REQ-030 sw_in[1] rises in the same cycle as a clearing read of 0x0001 -> bit1 still set on the following read.
REQ-031 PRESCALE=2, TIMER_MAX=3, run 8 cycles -> counts 0,1,2,3,0 and status=16'h0001; clearing read -> 16'h0000.
REQ-032 Assert reset with timer count=2 -> count 0 immediately; after release, first tick occurs PRESCALE cycles later.
REQ-033 Build without IO_PERIF_TIMER_EN, run 100 cycles -> 0x0002 and 0x0003 read 16'h0000.
